// File: rtl/cmd_pkg.sv
// Shared types and host protocol constants for the Knight's Tour command receiver.
package cmd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } asm_state_t;

  typedef enum logic [7:0] {
    HOST_ACK        = 8'hA5,
    HOST_TOUR_START = 8'h5A
  } host_byte_t;

  // The opcode occupies cmd[15:12]; the rest is the operand.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] operand;
  } cmd_t;

endpackage

// File: rtl/cmd_rcvr_if.sv
// Serial line and command handshake between the host link, the receiver and the command processor.
interface cmd_rcvr_if;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frame_err;

  modport slave (
    input  RX,
    input  clr_cmd_rdy,
    output cmd,
    output cmd_rdy,
    output frame_err
  );

  modport master (
    output RX,
    output clr_cmd_rdy,
    input  cmd,
    input  cmd_rdy,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte engine: two-flop RX synchronizer, mid-bit sampling, one-cycle result pulses.
module uart_rx_byte
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       start_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  rx_state_t state, next_state;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          tick;
  logic          load_half, load_full, shift_en, byte_ok, byte_bad, accept;

  assign tick    = (baud_cnt == '0);
  assign busy    = (state != RX_IDLE);
  assign rx_data = shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (!rx_sync) next_state = RX_START;
      RX_START: if (tick) next_state = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 4'd7) next_state = RX_STOP;
      RX_STOP:  if (tick) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  // A high line at the start-bit sample is a glitch and is dropped silently.
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    accept    = 1'b0;
    case (state)
      RX_IDLE:  load_half = !rx_sync;
      RX_START: begin
        accept    = tick && !rx_sync;
        load_full = tick && !rx_sync;
      end
      RX_DATA:  begin
        shift_en  = tick;
        load_full = tick;
      end
      RX_STOP:  begin
        byte_ok  = tick && rx_sync;
        byte_bad = tick && !rx_sync;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_rdy    <= 1'b0;
      start_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_rdy    <= byte_ok;
      start_ok  <= accept;
      frame_err <= byte_bad;
      if (load_half)      baud_cnt <= HALF_M1;
      else if (load_full) baud_cnt <= FULL_M1;
      else if (!tick)     baud_cnt <= baud_cnt - 1'b1;
      if (accept)        bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
    end
  end

endmodule

// File: rtl/cmd_rcvr.sv
// Command receiver: pairs bytes from the UART engine into 16-bit commands, high byte first.
module cmd_rcvr
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 1 << 20
) (
  input  logic       clk,
  input  logic       rst,
  cmd_rcvr_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  asm_state_t state, next_state;
  logic [7:0]    rx_data;
  logic          rx_rdy, start_ok, rx_ferr, busy;
  logic [7:0]    hi_byte;
  logic [TW-1:0] to_cnt;
  logic          timed_out, latch_hi, assemble, clr_by_start;
  cmd_t          cmd_q;
  logic          cmd_rdy_q, ferr_q;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (bus.RX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .start_ok  (start_ok),
    .frame_err (rx_ferr),
    .busy      (busy)
  );

  assign timed_out = (state == WAIT_LO) && !busy && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HI;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_HI: if (rx_rdy) next_state = WAIT_LO;
      WAIT_LO: if (rx_rdy || rx_ferr || timed_out) next_state = WAIT_HI;
      default: next_state = WAIT_HI;
    endcase
  end

  always_comb begin
    latch_hi     = 1'b0;
    assemble     = 1'b0;
    clr_by_start = 1'b0;
    case (state)
      WAIT_HI: begin
        latch_hi     = rx_rdy;
        clr_by_start = start_ok;
      end
      WAIT_LO: assemble = rx_rdy;
      default: ;
    endcase
  end

  // Assembly beats a same-cycle clear so a freshly completed command is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_byte   <= '0;
      to_cnt    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= rx_ferr;
      if (latch_hi) hi_byte <= rx_data;
      if (state != WAIT_LO || busy) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;
      if (assemble) begin
        cmd_q     <= cmd_t'({hi_byte, rx_data});
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy || clr_by_start) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_cmd_rcvr.sv
// Self-checking bench for cmd_rcvr: directed host scenarios plus random byte traffic vs. a frame-level model.
module tb_cmd_rcvr;

  localparam int B         = 16;
  localparam int H         = B / 2;
  localparam int TO        = 200;
  localparam int START_LAT = 4 + H;
  localparam int DONE_LAT  = 4 + H + 9 * B;

  logic clk = 1'b0;
  logic rst;
  cmd_rcvr_if bus ();

  cmd_rcvr #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic clr_q = 1'b0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_q <= bus.clr_cmd_rdy;
    rst_q <= rst;
  end

  // Model: each launched byte schedules its visible effects at the cycle the outputs must show them.
  logic [15:0] set_at[int];
  bit          ferr_at[int];
  bit          start_at[int];
  bit          clr_plan[int];
  logic [15:0] exp_cmd  = '0;
  logic        exp_rdy  = 1'b0;
  logic        exp_ferr = 1'b0;
  bit          hi_pending = 1'b0;
  logic [7:0]  hi_val = '0;
  int          hi_launch = 0;
  int          n_vec = 0, n_miss = 0, ferr_cnt = 0;
  int          n2, r, gap;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelByte(input logic [7:0] b, input bit good);
    int n;
    bit in_lo;
    n     = cyc;
    in_lo = hi_pending && ((n - (hi_launch + 10 * B)) < TO);
    if (!in_lo) start_at[n + START_LAT] = 1'b1;
    if (!good) begin
      ferr_at[n + DONE_LAT] = 1'b1;
      hi_pending = 1'b0;
    end else if (in_lo) begin
      set_at[n + DONE_LAT] = {hi_val, b};
      hi_pending = 1'b0;
    end else begin
      hi_pending = 1'b1;
      hi_val     = b;
      hi_launch  = n;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit good = 1'b1);
    modelByte(b, good);
    bus.RX = 1'b0;
    waitCycles(B);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      waitCycles(B);
    end
    bus.RX = good;
    waitCycles(B);
    bus.RX = 1'b1;
    if (!good) waitCycles(B);
  endtask

  task automatic glitch();
    bus.RX = 1'b0;
    waitCycles(B / 4);
    bus.RX = 1'b1;
    waitCycles(2 * B);
  endtask

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    forever begin
      @(negedge clk);
      bus.clr_cmd_rdy = (clr_plan.exists(cyc) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        exp_cmd  = '0;
        exp_rdy  = 1'b0;
        exp_ferr = 1'b0;
        set_at.delete();
        ferr_at.delete();
        start_at.delete();
        hi_pending = 1'b0;
      end else begin
        exp_ferr = (ferr_at.exists(cyc) != 0);
        if (clr_q || start_at.exists(cyc) != 0) exp_rdy = 1'b0;
        if (set_at.exists(cyc) != 0) begin
          exp_cmd = set_at[cyc];
          exp_rdy = 1'b1;
        end
      end
      if (bus.frame_err) ferr_cnt++;
      checkOutput("cmd", bus.cmd, exp_cmd);
      checkOutput("cmd_rdy", 16'(bus.cmd_rdy), 16'(exp_rdy));
      checkOutput("frame_err", 16'(bus.frame_err), 16'(exp_ferr));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    bus.RX = 1'b1;
    waitCycles(4);
    checkOutput("reset_cmd", bus.cmd, 16'h0000);
    checkOutput("reset_rdy", 16'(bus.cmd_rdy), 16'h0000);
    checkOutput("reset_ferr", 16'(bus.frame_err), 16'h0000);
    rst = 1'b0;
    waitCycles(2 * B);

    applyStimulus(8'h20);
    n2 = cyc;
    fork
      applyStimulus(8'h01);
      begin
        waitCycles(DONE_LAT - 1);
        checkOutput("rdy_before_done", 16'(bus.cmd_rdy), 16'h0000);
        waitCycles(1);
        checkOutput("single_cmd", bus.cmd, 16'h2001);
        checkOutput("single_rdy", 16'(bus.cmd_rdy), 16'h0001);
      end
    join
    waitCycles(20);
    checkOutput("rdy_held", 16'(bus.cmd_rdy), 16'h0001);
    clr_plan[cyc + 1] = 1'b1;
    waitCycles(2);
    checkOutput("rdy_cleared", 16'(bus.cmd_rdy), 16'h0000);
    checkOutput("cmd_kept", bus.cmd, 16'h2001);

    applyStimulus(8'h4F);
    clr_plan[cyc + DONE_LAT - 1] = 1'b1;
    applyStimulus(8'hF3);
    checkOutput("collide_cmd", bus.cmd, 16'h4FF3);
    checkOutput("collide_rdy", 16'(bus.cmd_rdy), 16'h0001);

    applyStimulus(8'hAB);
    waitCycles(TO + 10);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    checkOutput("timeout_cmd", bus.cmd, 16'h1234);

    ferr_cnt = 0;
    applyStimulus(8'h55, 1'b0);
    waitCycles(2 * B);
    checkOutput("ferr_pulses", 16'(ferr_cnt), 16'h0001);
    applyStimulus(8'h60);
    applyStimulus(8'h00);
    checkOutput("after_ferr_cmd", bus.cmd, 16'h6000);

    ferr_cnt = 0;
    glitch();
    waitCycles(B);
    checkOutput("glitch_cmd", bus.cmd, 16'h6000);
    checkOutput("glitch_rdy", 16'(bus.cmd_rdy), 16'h0001);
    checkOutput("glitch_ferr", 16'(ferr_cnt), 16'h0000);

    fork
      applyStimulus(8'h7F);
      begin
        waitCycles(5 * B);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("midrst_cmd", bus.cmd, 16'h0000);
        checkOutput("midrst_rdy", 16'(bus.cmd_rdy), 16'h0000);
      end
    join
    waitCycles(2 * TO + 10 * B);
    applyStimulus(8'h7F);
    applyStimulus(8'hFF);
    checkOutput("after_rst_cmd", bus.cmd, 16'h7FFF);

    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(99));
      if ($urandom_range(3) == 0) clr_plan[cyc + 1 + int'($urandom_range(400))] = 1'b1;
      if (r < 8 && !hi_pending) glitch();
      else if (r < 16)          applyStimulus(8'($urandom), 1'b0);
      else                      applyStimulus(8'($urandom), 1'b1);
      gap = ($urandom_range(3) == 0) ? int'($urandom_range(TO + 80, TO + 20))
                                     : int'($urandom_range(60));
      waitCycles(gap);
    end
    waitCycles(DONE_LAT + 2 * B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cmd_rcvr.md
# cmd_rcvr

Serial command receiver for the Knight's Tour robot. It deserializes the host's 8N1 UART stream and assembles each pair of bytes into a 16-bit command, high byte first. It presents the result to the command processor as `cmd`/`cmd_rdy`, and stays there until the command is consumed. It is the robot-side counterpart of the host command sender.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud). Must be ≥ 8.
- `TIMEOUT`, default 2^20: maximum clocks between the stop bit of the high byte and the start bit of the low byte.
- `clk` input, 1 bit: system clock. One clock domain only.
- `rst` input, 1 bit: synchronous, active-high reset.
- `RX` input, 1 bit: asynchronous serial line. Idles high.
- `clr_cmd_rdy` input, 1 bit: consumer acknowledge. Clears `cmd_rdy`.
- `cmd` output, 16 bits: last complete command. Reset value 16'h0000.
- `cmd_rdy` output, 1 bit: a new command is valid. Reset value 0.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit is bad. Reset value 0.

## Operation
- **Input sync:** `RX` passes through 2 flops, both preset to 1 on reset. All logic uses the synchronized value.
- **Byte engine states:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized low loads the baud counter with BAUD_DIV/2 and enters START.
  - START: at count expiry, the line is re-sampled. If it is high, the start was a glitch; return to IDLE with no error. If it is low, reload BAUD_DIV and enter DATA.
  - DATA: samples 8 bits at mid-bit, LSB first, into a shift register. A 4-bit counter counts the bits.
  - STOP: samples mid-bit. High means the byte is valid. Low means `frame_err` pulses for one cycle and the byte is discarded. Either way, return to IDLE.
- **Assembly FSM states:** WAIT_HI, WAIT_LO.
  - WAIT_HI: a valid byte is latched as the high byte; go to WAIT_LO and start the timeout counter.
  - WAIT_LO: a valid byte updates `cmd` to {hi, lo} and sets `cmd_rdy`; go to WAIT_HI.
  - If TIMEOUT clocks pass with the byte engine still IDLE, discard the high byte and go to WAIT_HI.
  - A framing error in WAIT_LO discards the high byte and goes to WAIT_HI.
- **`cmd_rdy`:** set on assembly. Cleared by `clr_cmd_rdy`, or when a start bit of a new high byte is accepted in WAIT_HI.
  - If set and clear happen in the same cycle, set wins.
- **`cmd`:** changes only on assembly. Holds its value otherwise, including after `cmd_rdy` clears.
- **Overrun:** a new command overwrites `cmd` even if `cmd_rdy` was never cleared. No error is flagged.
- **Reset mid-frame:** every FSM returns to IDLE/WAIT_HI and all outputs return to their reset values. The remainder of the interrupted frame is then parsed as a new frame.

## Timing
- **Bit sampling:** the start bit is sampled BAUD_DIV/2 clocks after the synchronized falling edge. Each later sample is BAUD_DIV clocks after the previous one.
- **Input latency:** 2 clocks from `RX` to the synchronized value.
- **Output latency:** `cmd` and `cmd_rdy` update exactly 1 clock after the low byte's stop-bit sample.
- **Command duration:** about 20·BAUD_DIV clocks for back-to-back bytes.
- **`frame_err`:** asserts 1 clock after the bad stop-bit sample, for exactly 1 clock.
- **Clear:** `clr_cmd_rdy` takes effect on the next clock edge.

## Structure
- The shared package `cmd_pkg` holds:
  - the byte-engine state enum `rx_state_t`;
  - the assembly state enum `asm_state_t`;
  - the host constants: ack 8'hA5, tour start 8'h5A, and the opcode field positions `cmd[15:12]`.
- Natural sub-module: `uart_rx_byte`, containing the synchronizer and byte engine. Its outputs are `rx_data[7:0]`, a `rx_rdy` one-cycle pulse, `frame_err`, and `busy`.
- `cmd_rcvr` itself contains the assembly FSM, the timeout counter and the output registers.

## Test plan
- **Single command:** with BAUD_DIV=16, send bytes 8'h20 then 8'h01 back-to-back.
  - `cmd`=16'h2001 and `cmd_rdy`=1, appearing 1 clock after the second stop sample.
  - `cmd_rdy` stays 1 until `clr_cmd_rdy` pulses, then reads 0 the next clock.
- **Set/clear collision:** assert `clr_cmd_rdy` in the same cycle as completion of 16'h4FF3.
  - `cmd_rdy`=1.
- **Inter-byte timeout:** send 8'hAB, wait TIMEOUT+10 clocks, then send 8'h12 and 8'h34.
  - `cmd`=16'h1234, never 16'hAB12.
- **Framing error:** send 8'h55 with the stop bit forced low.
  - `frame_err` pulses for exactly 1 clock.
  - The FSM stays in WAIT_HI; the next pair 8'h60/8'h00 gives 16'h6000.
- **Glitch rejection:** hold `RX` low for BAUD_DIV/4 clocks, then release it.
  - No byte is received, no `frame_err`, and `cmd` is unchanged.
- **Reset mid-frame:** assert `rst` during DATA of the high byte.
  - `cmd`=0, `cmd_rdy`=0.
  - After idling, a clean pair 8'h7F/8'hFF gives 16'h7FFF.
